// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-cycle hazard priority,
// a RUN/DMEM_WAIT/HALTED FSM, a sticky pending redirect and saturating counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             uses_rt_IF_ID,
    input  logic             redirect_EX,
    input  logic             halt_MEM_WB,
    output logic             pc_en,
    output logic             enable_IF_ID,
    output logic             flush_IF_ID,
    output logic             enable_ID_EX,
    output logic             flush_ID_EX,
    output logic             enable_EX_MEM,
    output logic             flush_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t state, state_next;
    logic   redirect_pend, pend_next;
    logic   flush_inc;
    logic   dwait, redir, load_use;

    assign dwait    = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
    assign redir    = redirect_EX | redirect_pend;
    assign load_use = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                      ((Rt_ID_EX == Rs_IF_ID) | (uses_rt_IF_ID & (Rt_ID_EX == Rt_IF_ID)));

    assign halted    = (state == HALTED);
    assign state_dbg = state;

    always_comb begin
        state_next    = state;
        pend_next     = redirect_pend;
        flush_inc     = 1'b0;
        pc_en         = 1'b1;
        enable_IF_ID  = 1'b1;
        flush_IF_ID   = 1'b0;
        enable_ID_EX  = 1'b1;
        flush_ID_EX   = 1'b0;
        enable_EX_MEM = 1'b1;
        flush_EX_MEM  = 1'b0;
        enable_MEM_WB = 1'b1;

        if (RST) begin
            pc_en         = 1'b0;
            enable_IF_ID  = 1'b0;
            enable_ID_EX  = 1'b0;
            enable_EX_MEM = 1'b0;
            enable_MEM_WB = 1'b0;
            flush_IF_ID   = 1'b1;
            flush_ID_EX   = 1'b1;
            flush_EX_MEM  = 1'b1;
        end else if (state == HALTED || halt_MEM_WB || dwait) begin
            // Whole pipe frozen; a redirect arriving during a data wait is remembered.
            pc_en         = 1'b0;
            enable_IF_ID  = 1'b0;
            enable_ID_EX  = 1'b0;
            enable_EX_MEM = 1'b0;
            enable_MEM_WB = 1'b0;
            if (state != HALTED) begin
                if (halt_MEM_WB) begin
                    state_next = HALTED;
                end else begin
                    state_next = DMEM_WAIT;
                    if (redirect_EX) pend_next = 1'b1;
                end
            end
        end else begin
            state_next = RUN;
            if (redir) begin
                // Redirect PC is only written once the fetch slot frees up.
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                pc_en       = ihit;
                pend_next   = ~ihit;
                flush_inc   = ihit;
            end else if (load_use) begin
                pc_en        = 1'b0;
                enable_IF_ID = 1'b0;
                flush_ID_EX  = 1'b1;
            end else if (!ihit) begin
                pc_en       = 1'b0;
                flush_IF_ID = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
        end else begin
            state         <= state_next;
            redirect_pend <= pend_next;
            if (!pc_en && state != HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl; a second CNT_W=2
// instance shares the stimulus so counter saturation is exercised.
module tb_pipeline_hazard_ctrl;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX;
    logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
    logic uses_rt_IF_ID, redirect_EX, halt_MEM_WB;

    logic pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
    logic enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted;
    logic [31:0] stall_cycles, flush_count;
    logic [1:0]  state_dbg;

    logic n_pc_en, n_en_ifid, n_fl_ifid, n_en_idex, n_fl_idex;
    logic n_en_exmem, n_fl_exmem, n_en_memwb, n_halted;
    logic [1:0] n_stall, n_flush, n_state;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .dREN_ID_EX(dREN_ID_EX),
        .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
        .uses_rt_IF_ID(uses_rt_IF_ID), .redirect_EX(redirect_EX), .halt_MEM_WB(halt_MEM_WB),
        .pc_en(pc_en), .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
        .enable_ID_EX(enable_ID_EX), .flush_ID_EX(flush_ID_EX),
        .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .enable_MEM_WB(enable_MEM_WB), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .state_dbg(state_dbg)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) dut_narrow (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .dREN_ID_EX(dREN_ID_EX),
        .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
        .uses_rt_IF_ID(uses_rt_IF_ID), .redirect_EX(redirect_EX), .halt_MEM_WB(halt_MEM_WB),
        .pc_en(n_pc_en), .enable_IF_ID(n_en_ifid), .flush_IF_ID(n_fl_ifid),
        .enable_ID_EX(n_en_idex), .flush_ID_EX(n_fl_idex),
        .enable_EX_MEM(n_en_exmem), .flush_EX_MEM(n_fl_exmem),
        .enable_MEM_WB(n_en_memwb), .halted(n_halted),
        .stall_cycles(n_stall), .flush_count(n_flush), .state_dbg(n_state)
    );

    // {pc_en, en_IF_ID, fl_IF_ID, en_ID_EX, fl_ID_EX, en_EX_MEM, fl_EX_MEM, en_MEM_WB}
    localparam logic [7:0] C_RESET  = 8'b0010_1010;
    localparam logic [7:0] C_NORM   = 8'b1101_0101;
    localparam logic [7:0] C_FROZEN = 8'b0000_0000;
    localparam logic [7:0] C_LU     = 8'b0001_1101;
    localparam logic [7:0] C_FMISS  = 8'b0111_0101;
    localparam logic [7:0] C_RWAIT  = 8'b0111_1101;
    localparam logic [7:0] C_RGO    = 8'b1111_1101;
    localparam logic [1:0] S_RUN = 2'd0, S_DW = 2'd1, S_HALT = 2'd2;

    logic [7:0] ctrl, n_ctrl;
    assign ctrl   = {pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
                     enable_EX_MEM, flush_EX_MEM, enable_MEM_WB};
    assign n_ctrl = {n_pc_en, n_en_ifid, n_fl_ifid, n_en_idex, n_fl_idex,
                     n_en_exmem, n_fl_exmem, n_en_memwb};

    typedef struct {
        logic       rst, ih, dh, drm, dwm, dre;
        logic [4:0] rte, rsi, rti;
        logic       ur, rd, ht;
        logic [7:0] c;
        logic [1:0] st;
        logic       hl;
        int         sc, fc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic rst, ih, dh, drm, dwm, dre,
                                input int rte, rsi, rti, input logic ur, rd, ht,
                                input logic [7:0] c, input logic [1:0] st,
                                input logic hl, input int sc, fc);
        vec_t v;
        v.rst = rst; v.ih = ih; v.dh = dh; v.drm = drm; v.dwm = dwm; v.dre = dre;
        v.rte = rte[4:0]; v.rsi = rsi[4:0]; v.rti = rti[4:0];
        v.ur = ur; v.rd = rd; v.ht = ht;
        v.c = c; v.st = st; v.hl = hl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic logic [1:0] sat2(input int x);
        return (x > 3) ? 2'd3 : x[1:0];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        RST = v.rst; ihit = v.ih; dhit = v.dh;
        dREN_EX_MEM = v.drm; dWEN_EX_MEM = v.dwm; dREN_ID_EX = v.dre;
        Rt_ID_EX = v.rte; Rs_IF_ID = v.rsi; Rt_IF_ID = v.rti;
        uses_rt_IF_ID = v.ur; redirect_EX = v.rd; halt_MEM_WB = v.ht;
    endtask

    task automatic check_status(input string nm, input logic [1:0] st, input logic hl,
                                input int sc, input int fc);
        chk({nm, "_status"}, {state_dbg, halted, stall_cycles, flush_count},
            {st, hl, sc[31:0], fc[31:0]});
        chk({nm, "_narrow"}, {n_state, n_halted, n_stall, n_flush, n_ctrl},
            {st, hl, sat2(sc), sat2(fc), ctrl});
    endtask

    initial begin
        //            rst ih dh drm dwm dre rte rsi rti ur rd ht ctrl      state  hl sc fc
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RESET,  S_RUN,  0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, C_LU,     S_RUN,  0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, C_NORM,   S_RUN,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0, C_LU,     S_RUN,  0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 7, 3, 7, 0, 0, 0, C_NORM,   S_RUN,  0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_FROZEN, S_RUN,  0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_FROZEN, S_DW,   0, 3, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_FROZEN, S_DW,   0, 4, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_DW,   0, 5, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RWAIT,  S_RUN,  0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RWAIT,  S_RUN,  0, 6, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RGO,    S_RUN,  0, 7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 7, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0, C_RGO,    S_RUN,  0, 7, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 7, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_FMISS,  S_RUN,  0, 7, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 8, 2));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, S_RUN,  0, 8, 2));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_RGO,    S_DW,   0, 9, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 9, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FROZEN, S_RUN,  0, 9, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, C_FROZEN, S_HALT, 1, 10, 3));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 5, 5, 5, 1, 0, 0, C_FROZEN, S_HALT, 1, 10, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RESET,  S_HALT, 1, 10, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM,   S_RUN,  0, 0, 0));

        // Initial reset: two edges with RST held high.
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RESET, S_RUN, 0, 0, 0));
        repeat (2) @(posedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctrl", i), 128'(ctrl), 128'(vecs[i].c));
            check_status($sformatf("vec%0d", i), vecs[i].st, vecs[i].hl, vecs[i].sc, vecs[i].fc);
        end

        // Halt persists through random input activity; counters stay frozen.
        @(negedge CLK);
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_FROZEN, S_RUN, 0, 0, 0));
        #1;
        chk("halt_entry_ctrl", 128'(ctrl), 128'(C_FROZEN));
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            RST = 1'b0;
            ihit = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
            dREN_EX_MEM = 1'($urandom_range(0, 1)); dWEN_EX_MEM = 1'($urandom_range(0, 1));
            dREN_ID_EX = 1'($urandom_range(0, 1)); uses_rt_IF_ID = 1'($urandom_range(0, 1));
            redirect_EX = 1'($urandom_range(0, 1)); halt_MEM_WB = 1'($urandom_range(0, 1));
            Rt_ID_EX = 5'($urandom_range(0, 31)); Rs_IF_ID = 5'($urandom_range(0, 31));
            Rt_IF_ID = 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("halted%0d_ctrl", k), 128'(ctrl), 128'(C_FROZEN));
            check_status($sformatf("halted%0d", k), S_HALT, 1'b1, 1, 0);
        end

        // One reset edge brings the controller back to RUN with cleared counters.
        @(negedge CLK);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RESET, S_RUN, 0, 0, 0));
        #1;
        chk("halt_reset_ctrl", 128'(ctrl), 128'(C_RESET));
        @(negedge CLK);
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, S_RUN, 0, 0, 0));
        #1;
        chk("post_reset_ctrl", 128'(ctrl), 128'(C_NORM));
        check_status("post_reset", S_RUN, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
